// File: rtl/debug_inputs_wb.sv
// Debounces NUM_INPUTS asynchronous debug inputs and reports every debounced change
// as a Wishbone pipelined write, buffering events in a small FIFO while the bus is busy.
module debug_inputs_wb #(
  parameter int          NUM_INPUTS      = 8,
  parameter int          DEBOUNCE_PERIOD = 5_000_000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          DATA_WIDTH      = 32,
  parameter logic [31:0] TARGET_ADDR     = 32'h0,
  parameter int          MAX_RETRIES     = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_INPUTS-1:0]         inputs_i,
  output logic                          cyc_o,
  output logic                          stb_o,
  output logic                          we_o,
  output logic [31:0]                   adr_o,
  output logic [DATA_WIDTH-1:0]         dat_o,
  output logic [DATA_WIDTH/8-1:0]       sel_o,
  input  logic                          ack_i,
  input  logic                          err_i,
  input  logic                          rty_i,
  input  logic                          stall_i,
  output logic [NUM_INPUTS-1:0]         debounced_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [7:0]                    dropped_o
);

  localparam int             CW          = $clog2(DEBOUNCE_PERIOD + 1);
  localparam logic [CW-1:0]  CNT_LAST    = CW'(DEBOUNCE_PERIOD - 1);
  localparam int             AW          = $clog2(FIFO_DEPTH);
  localparam int             LW          = AW + 1;
  localparam logic [LW-1:0]  FULL_LEVEL  = LW'(FIFO_DEPTH);
  localparam int             RW          = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0]  RETRY_LIMIT = RW'(MAX_RETRIES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_BACKOFF
  } state_t;

  logic [NUM_INPUTS-1:0] r_sync1;
  logic [NUM_INPUTS-1:0] r_sync2;
  logic [NUM_INPUTS-1:0] r_debounced;
  logic [NUM_INPUTS-1:0] r_prev;
  logic [CW-1:0]         r_cnt [NUM_INPUTS];
  logic                  r_pendingDrop;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wrPtr;
  logic [AW-1:0]         r_rdPtr;
  logic [LW-1:0]         r_level;
  logic [7:0]            r_dropped;
  state_t                r_state;
  logic [RW-1:0]         r_retries;
  logic                  r_cyc;
  logic                  r_stb;
  logic [DATA_WIDTH-1:0] r_dat;

  logic                  w_change;
  logic [DATA_WIDTH-1:0] w_eventWord;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_busDrop;
  logic                  w_pushAccept;
  logic                  w_pushDrop;
  logic [1:0]            w_dropInc;
  logic [8:0]            w_dropSum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= inputs_i;
      r_sync2 <= r_sync1;
    end
  end

  // A channel flips only after its synced value has disagreed for DEBOUNCE_PERIOD cycles in a row.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        r_cnt[i] <= '0;
      end
      r_debounced <= '0;
      r_prev      <= '0;
    end else begin
      r_prev <= r_debounced;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (r_sync2[i] == r_debounced[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_debounced[i] <= r_sync2[i];
          r_cnt[i]       <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_change = (r_debounced != r_prev);

  always_comb begin
    w_eventWord                             = '0;
    w_eventWord[NUM_INPUTS-1:0]             = r_debounced;
    w_eventWord[2*NUM_INPUTS-1:NUM_INPUTS]  = r_debounced ^ r_prev;
    w_eventWord[DATA_WIDTH-1]               = r_pendingDrop;
  end

  assign w_full       = (r_level == FULL_LEVEL);
  assign w_empty      = (r_level == '0);
  assign w_pushAccept = w_change && (!w_full || w_pop);
  assign w_pushDrop   = w_change && w_full && !w_pop;

  always_ff @(posedge clk_i) begin
    if (w_pushAccept) begin
      r_mem[r_wrPtr] <= w_eventWord;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_level       <= '0;
      r_pendingDrop <= 1'b0;
    end else begin
      if (w_pushAccept) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_pushAccept, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_pushDrop) begin
        r_pendingDrop <= 1'b1;
      end else if (w_pushAccept) begin
        r_pendingDrop <= 1'b0;
      end
    end
  end

  // Completion decode; err outranks rty, which outranks ack.
  always_comb begin
    w_pop     = 1'b0;
    w_busDrop = 1'b0;
    case (r_state)
      S_STROBE: begin
        if (!stall_i && ack_i) begin
          w_pop = 1'b1;
        end
      end
      S_WAIT: begin
        if (err_i) begin
          w_pop     = 1'b1;
          w_busDrop = 1'b1;
        end else if (rty_i) begin
          if (r_retries >= RETRY_LIMIT) begin
            w_pop     = 1'b1;
            w_busDrop = 1'b1;
          end
        end else if (ack_i) begin
          w_pop = 1'b1;
        end
      end
      default: begin
        w_pop     = 1'b0;
        w_busDrop = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_dat     <= '0;
      r_retries <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_dat     <= r_mem[r_rdPtr];
            r_cyc     <= 1'b1;
            r_stb     <= 1'b1;
            r_retries <= '0;
            r_state   <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (!stall_i) begin
            r_stb <= 1'b0;
            if (ack_i) begin
              r_cyc   <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (err_i) begin
            r_cyc   <= 1'b0;
            r_state <= S_IDLE;
          end else if (rty_i) begin
            r_cyc <= 1'b0;
            if (r_retries >= RETRY_LIMIT) begin
              r_state <= S_IDLE;
            end else begin
              r_retries <= r_retries + 1'b1;
              r_state   <= S_BACKOFF;
            end
          end else if (ack_i) begin
            r_cyc   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_BACKOFF: begin
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_state <= S_STROBE;
        end
        default: begin
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A FIFO overflow and a bus-side discard can land in the same cycle.
  assign w_dropInc = {1'b0, w_pushDrop} + {1'b0, w_busDrop};
  assign w_dropSum = {1'b0, r_dropped} + {7'd0, w_dropInc};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dropped <= '0;
    end else begin
      r_dropped <= w_dropSum[8] ? 8'hFF : w_dropSum[7:0];
    end
  end

  assign cyc_o        = r_cyc;
  assign stb_o        = r_stb;
  assign we_o         = 1'b1;
  assign adr_o        = TARGET_ADDR;
  assign dat_o        = r_dat;
  assign sel_o        = '1;
  assign debounced_o  = r_debounced;
  assign fifo_level_o = r_level;
  assign dropped_o    = r_dropped;

endmodule

// File: tb/tb_debug_inputs_wb.sv
// Bench for debug_inputs_wb: directed scenarios plus randomized inputs and bus responses,
// all checked against a behavioural model of debounce, event queue and drop counting.
module tb_debug_inputs_wb;

  localparam int          N    = 8;
  localparam int          DP   = 4;
  localparam int          FD   = 2;
  localparam int          DW   = 32;
  localparam int          MAXR = 2;
  localparam logic [31:0] ADDR = 32'h1000_0040;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  inputs_i = '0;
  logic          cyc_o, stb_o, we_o;
  logic [31:0]   adr_o;
  logic [DW-1:0] dat_o;
  logic [3:0]    sel_o;
  logic          ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0, stall_i = 1'b0;
  logic [N-1:0]  debounced_o;
  logic [1:0]    fifo_level_o;
  logic [7:0]    dropped_o;

  always #5 clk = ~clk;

  debug_inputs_wb #(
    .NUM_INPUTS(N), .DEBOUNCE_PERIOD(DP), .FIFO_DEPTH(FD),
    .DATA_WIDTH(DW), .TARGET_ADDR(ADDR), .MAX_RETRIES(MAXR)
  ) dut (
    .clk_i(clk), .rst_i(rst), .inputs_i(inputs_i),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .dat_o(dat_o), .sel_o(sel_o),
    .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i), .stall_i(stall_i),
    .debounced_o(debounced_o), .fifo_level_o(fifo_level_o), .dropped_o(dropped_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Model state: raw input samples per edge, expected debounced value, event queue, drops.
  logic [N-1:0]  inHist [DP+1];
  logic [N-1:0]  mDeb, mPrev;
  logic [DW-1:0] mQ[$];
  logic          mPd;
  int            mDrops, mAttempts, mDropsNow;
  bit            mPopNow, mAllDiffer, expectCycLow, expectStbLow, checkEnable;
  logic [DW-1:0] mWord;
  logic [DW-1:0] wordLog[$];

  int respMode = 0;
  int rtyLeft = 0;
  int stallMode = 0;
  bit slaveAccepted;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= DP; k++) inHist[k] = '0;
      mDeb = '0; mPrev = '0; mQ.delete(); mPd = 1'b0;
      mDrops = 0; mAttempts = 0; expectCycLow = 0; expectStbLow = 0;
    end else begin
      mPopNow = 0;
      mDropsNow = 0;
      if (cyc_o && stb_o && !stall_i) begin
        wordLog.push_back(dat_o);
        expectStbLow = 1;
        if (mQ.size() == 0) failNow("busWordWithEmptyQueue");
        else checkOutput("busWord", dat_o, mQ[0]);
        checkOutput("busAdr", adr_o, ADDR);
        checkOutput("busWeSel", {27'd0, we_o, sel_o}, {27'd0, 1'b1, 4'hF});
      end
      if (err_i) begin
        mPopNow = 1; mDropsNow++;
      end else if (rty_i) begin
        if (mAttempts >= MAXR) begin
          mPopNow = 1; mDropsNow++;
        end else begin
          mAttempts++;
        end
      end else if (ack_i) begin
        mPopNow = 1;
      end
      if (ack_i || err_i || rty_i) expectCycLow = 1;
      if (mPopNow && mQ.size() > 0) begin
        void'(mQ.pop_front());
        mAttempts = 0;
      end
      if (mDeb != mPrev) begin
        mWord = '0;
        mWord[N-1:0] = mDeb;
        mWord[2*N-1:N] = mDeb ^ mPrev;
        mWord[DW-1] = mPd;
        if (mQ.size() < FD) begin
          mQ.push_back(mWord);
          mPd = 1'b0;
        end else begin
          mPd = 1'b1;
          mDropsNow++;
        end
      end
      mDrops = (mDrops + mDropsNow > 255) ? 255 : mDrops + mDropsNow;
      mPrev = mDeb;
      for (int b = 0; b < N; b++) begin
        mAllDiffer = 1;
        for (int k = 1; k <= DP; k++) if (inHist[k][b] == mDeb[b]) mAllDiffer = 0;
        if (mAllDiffer) mDeb[b] = ~mDeb[b];
      end
      for (int k = DP; k >= 1; k--) inHist[k] = inHist[k-1];
      inHist[0] = inputs_i;
    end
  end

  // Slave: answers one cycle after each accepted strobe.
  always @(posedge clk) begin
    slaveAccepted = cyc_o && stb_o && !stall_i && !rst;
    #1;
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
    if (slaveAccepted && !rst) begin
      if (rtyLeft > 0) begin
        rty_i = 1'b1;
        rtyLeft--;
      end else if (respMode == 1) begin
        err_i = 1'b1;
      end else if (respMode == 2) begin
        case ($urandom_range(0, 3))
          0:       err_i = 1'b1;
          1:       rty_i = 1'b1;
          default: ack_i = 1'b1;
        endcase
      end else begin
        ack_i = 1'b1;
      end
    end
    stall_i = (stallMode == 1) || (stallMode == 2 && $urandom_range(0, 2) == 0);
  end

  always @(negedge clk) begin
    if (!rst && checkEnable) begin
      checkOutput("debounced", 32'(debounced_o), 32'(mDeb));
      checkOutput("fifoLevel", 32'(fifo_level_o), 32'(mQ.size()));
      checkOutput("dropped", 32'(dropped_o), 32'(mDrops));
      if (expectCycLow) begin
        checkOutput("cycGap", 32'(cyc_o), 32'd0);
        expectCycLow = 0;
      end
      if (expectStbLow) begin
        checkOutput("stbDrop", 32'(stb_o), 32'd0);
        expectStbLow = 0;
      end
    end
  end

  function automatic logic [31:0] logAt(input int idx);
    if (idx >= 0 && idx < wordLog.size()) return wordLog[idx];
    return 'x;
  endfunction

  // Called just after a rising edge; drives inputs and holds them for the given cycles.
  task automatic applyStimulus(input logic [N-1:0] value, input int hold);
    #2 inputs_i = value;
    repeat (hold) @(posedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1 rst = 1'b1;
    inputs_i = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string name);
    bit done;
    bit settled;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      settled = (inputs_i == mDeb);
      for (int k = 0; k <= DP; k++) if (inHist[k] != mDeb) settled = 0;
      if (settled && mQ.size() == 0 && mDeb == mPrev && !cyc_o) begin
        done = 1;
        break;
      end
    end
    if (!done) failNow({name, "Timeout"});
    @(posedge clk);
  endtask

  int base;
  bit seen;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    checkEnable = 1;
    @(negedge clk);
    checkOutput("resetCyc", 32'(cyc_o), 32'd0);
    checkOutput("resetLevel", 32'(fifo_level_o), 32'd0);
    @(posedge clk);

    // Reset during an active (stalled) transaction.
    stallMode = 1;
    applyStimulus(8'h01, 1);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cyc_o) begin seen = 1; break; end
    end
    if (!seen) failNow("cycRiseTimeout");
    checkOutput("preResetDeb", 32'(debounced_o), 32'h01);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstCycDrop", 32'(cyc_o), 32'd0);
    checkOutput("rstDeb", 32'(debounced_o), 32'd0);
    checkOutput("rstLevel", 32'(fifo_level_o), 32'd0);
    checkOutput("rstDropped", 32'(dropped_o), 32'd0);
    inputs_i = '0;
    stallMode = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);

    // Clean edge and pin-to-debounced latency.
    base = wordLog.size();
    applyStimulus(8'h05, 5);
    @(negedge clk);
    checkOutput("latency5", 32'(debounced_o), 32'h00);
    @(posedge clk);
    @(negedge clk);
    checkOutput("latency6", 32'(debounced_o), 32'h05);
    @(posedge clk);
    waitIdle(100, "clean");
    checkOutput("cleanWrites", 32'(wordLog.size() - base), 32'd1);
    checkOutput("cleanWord", logAt(base), 32'h0000_0505);

    // Bounce rejection.
    doReset();
    base = wordLog.size();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h01, 2);
      applyStimulus(8'h00, 2);
    end
    applyStimulus(8'h01, 3);
    @(negedge clk);
    checkOutput("bounceHold", 32'(debounced_o), 32'h00);
    @(posedge clk);
    waitIdle(100, "bounce");
    checkOutput("bounceWrites", 32'(wordLog.size() - base), 32'd1);
    checkOutput("bounceWord", logAt(base), 32'h0000_0101);

    // Overflow with the bus stalled.
    stallMode = 1;
    applyStimulus(8'h03, 8);
    applyStimulus(8'h07, 8);
    applyStimulus(8'h0F, 8);
    applyStimulus(8'h1F, 8);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("ovfLevel", 32'(fifo_level_o), 32'd2);
    checkOutput("ovfDropped", 32'(dropped_o), 32'd2);
    @(posedge clk);
    base = wordLog.size();
    stallMode = 0;
    waitIdle(100, "ovfDrain");
    checkOutput("ovfWrites", 32'(wordLog.size() - base), 32'd2);
    checkOutput("ovfWord0", logAt(base), 32'h0000_0203);
    checkOutput("ovfWord1", logAt(base + 1), 32'h0000_0407);
    base = wordLog.size();
    applyStimulus(8'h3F, 2);
    waitIdle(100, "ovfFlag");
    checkOutput("ovfFlagWord", logAt(base), 32'h8000_203F);

    // Retry exhaustion then a normal write.
    base = wordLog.size();
    rtyLeft = 3;
    applyStimulus(8'h7F, 2);
    waitIdle(200, "retry");
    checkOutput("retryWrites", 32'(wordLog.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) checkOutput("retryWord", logAt(base + i), 32'h0000_407F);
    checkOutput("retryDropped", 32'(dropped_o), 32'd3);
    base = wordLog.size();
    applyStimulus(8'hFF, 2);
    waitIdle(100, "afterRetry");
    checkOutput("afterRetryWord", logAt(base), 32'h0000_80FF);

    // Two channels in one debounced cycle, answered with err.
    base = wordLog.size();
    respMode = 1;
    applyStimulus(8'h77, 2);
    waitIdle(100, "err");
    checkOutput("errWord", logAt(base), 32'h0000_8877);
    checkOutput("errDropped", 32'(dropped_o), 32'd4);
    checkOutput("errCyc", 32'(cyc_o), 32'd0);
    checkOutput("errLevel", 32'(fifo_level_o), 32'd0);

    // Randomized inputs, stalls and responses.
    respMode = 2;
    stallMode = 2;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(N'($urandom), $urandom_range(1, 10));
    end
    respMode = 0;
    stallMode = 0;
    rtyLeft = 0;
    waitIdle(400, "randomDrain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
